// File: rtl/video_stream_tx.sv
// video_stream_tx: drives an upstream valid/ready pixel stream out as raster
// video timing (hs/vs/de/rgb) with active line/column indices. A slot is never
// stalled: a missing pixel goes out black and raises a sticky underflow flag.
// Misplaced start-of-frame markers raise a sticky sof_err flag.
module video_stream_tx #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        pix_sof,
  input  logic [23:0] pix_data,
  input  logic        clear_err,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [7:0]  rgb_r,
  output logic [7:0]  rgb_g,
  output logic [7:0]  rgb_b,
  output logic [11:0] line_counter,
  output logic [11:0] column_counter,
  output logic        frame_done,
  output logic        underflow,
  output logic        sof_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT     = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT     = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t      state, state_nxt;
  logic [11:0] h_cnt, v_cnt;
  logic        running, active, at_last, at_origin, in_hsync, in_vsync, accept;

  logic        hs_p1, vs_p1, de_p1, frame_done_p1;
  logic [23:0] rgb_p1;
  logic [11:0] line_p1, column_p1;

  // Sync output level for a given region membership and polarity.
  function automatic logic sync_level(input logic in_region, input logic pol);
    return in_region ? pol : ~pol;
  endfunction

  assign running   = (state != IDLE);
  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign at_last   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign at_origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);
  assign in_hsync  = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign in_vsync  = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign pix_ready = running && active;
  assign accept    = pix_ready && pix_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: stopping only ever leaves to IDLE on the last slot of a frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (enable) state_nxt = RUN;
      RUN:      if (!enable) state_nxt = STOPPING;
      STOPPING: begin
        if (enable)       state_nxt = RUN;
        else if (at_last) state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Raster position counters; held at the origin while idle.
  always_ff @(posedge clk) begin
    if (rst || !running) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Stage p1: registered timing, pixel and index outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_p1         <= ~HS_POL;
      vs_p1         <= ~VS_POL;
      de_p1         <= 1'b0;
      rgb_p1        <= '0;
      line_p1       <= '0;
      column_p1     <= '0;
      frame_done_p1 <= 1'b0;
    end else begin
      hs_p1         <= sync_level(running && in_hsync, HS_POL);
      vs_p1         <= sync_level(running && in_vsync, VS_POL);
      de_p1         <= pix_ready;
      rgb_p1        <= accept ? pix_data : 24'd0;
      line_p1       <= pix_ready ? v_cnt : 12'd0;
      column_p1     <= pix_ready ? h_cnt : 12'd0;
      frame_done_p1 <= running && at_last;
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      if (pix_ready && !pix_valid) underflow <= 1'b1;
      else if (clear_err)          underflow <= 1'b0;
      if (accept && (pix_sof != at_origin)) sof_err <= 1'b1;
      else if (clear_err)                   sof_err <= 1'b0;
    end
  end

  assign hs             = hs_p1;
  assign vs             = vs_p1;
  assign de             = de_p1;
  assign rgb_r          = rgb_p1[23:16];
  assign rgb_g          = rgb_p1[15:8];
  assign rgb_b          = rgb_p1[7:0];
  assign line_counter   = line_p1;
  assign column_counter = column_p1;
  assign frame_done     = frame_done_p1;

endmodule
